// File: rtl/axis_width_converter_keep_if.sv
// AXI-stream bundle (data, byte enables, end-of-packet) with valid/ready handshake.
// No logic, no latency: a plain wire bundle with direction views.
// The master drives tvalid/tdata/tkeep/tlast; the slave drives tready.
interface axis_width_converter_keep_if #(
  parameter int BYTES = 1
);
  logic               tready;
  logic               tvalid;
  logic               tlast;
  logic [BYTES-1:0]   tkeep;
  logic [8*BYTES-1:0] tdata;

  modport master (input tready, output tvalid, output tlast, output tkeep, output tdata);
  modport slave  (output tready, input tvalid, input tlast, input tkeep, input tdata);
endinterface

// File: rtl/axis_width_converter_keep.sv
// AXIS width converter with tkeep: packs narrow beats into wide words or unpacks wide words into slices.
// Latency: pack 1 clk from the completing input beat; unpack 1 clk from capture; equal widths combinational.
// Backpressure: full throughput; pack stalls input only while output is held; unpack accepts on the last slice handshake.
module axis_width_converter_keep #(
  parameter int AXIS_I_BYTES = 1,
  parameter int AXIS_O_BYTES = 1,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic                        clk,
  input  logic                        aresetn,
  axis_width_converter_keep_if.slave  axis_i,
  axis_width_converter_keep_if.master axis_o
);

  localparam int MAX_B = (AXIS_I_BYTES > AXIS_O_BYTES) ? AXIS_I_BYTES : AXIS_O_BYTES;
  localparam int MIN_B = (AXIS_I_BYTES > AXIS_O_BYTES) ? AXIS_O_BYTES : AXIS_I_BYTES;

  generate
    if ((MAX_B % MIN_B) != 0) begin : g_bad_ratio
      $error("axis_width_converter_keep: wider width must be an integer multiple of the narrower");
    end

    if (AXIS_I_BYTES == AXIS_O_BYTES) begin : g_pass
      // Same width: straight wires, clock and reset are not needed.
      wire pass_unused_ok = clk ^ aresetn;
      assign axis_i.tready = axis_o.tready;
      assign axis_o.tvalid = axis_i.tvalid;
      assign axis_o.tlast  = axis_i.tlast;
      assign axis_o.tkeep  = axis_i.tkeep;
      assign axis_o.tdata  = axis_i.tdata;

    end else if (AXIS_I_BYTES > AXIS_O_BYTES) begin : g_unpack
      localparam int RATIO = AXIS_I_BYTES / AXIS_O_BYTES;
      localparam int CW    = $clog2(RATIO);
      localparam int SB    = AXIS_O_BYTES;

      typedef enum logic {EMPTY, HOLD} state_t;
      state_t state, state_nxt;

      logic [CW-1:0]             ctr, ctr_nxt, last_idx, cap_last_idx, phys;
      logic [8*AXIS_I_BYTES-1:0] data_q;
      logic [AXIS_I_BYTES-1:0]   keep_q;
      logic                      last_q;
      logic                      cap_empty, in_fire, out_fire, at_last, capture;

      // Locate the highest logical slice carrying any enabled byte of the incoming word.
      always_comb begin
        cap_last_idx = '0;
        cap_empty    = 1'b1;
        for (int s = 0; s < RATIO; s++) begin
          if (|axis_i.tkeep[(MSB_FIRST ? (RATIO - 1 - s) : s) * SB +: SB]) begin
            cap_last_idx = CW'(s);
            cap_empty    = 1'b0;
          end
        end
      end

      assign phys     = MSB_FIRST ? (CW'(RATIO - 1) - ctr) : ctr;
      assign at_last  = (ctr == last_idx);
      assign out_fire = (state == HOLD) & axis_o.tready;
      assign in_fire  = axis_i.tvalid & axis_i.tready;
      // An empty non-final word is swallowed without producing output.
      assign capture  = in_fire & ~(cap_empty & ~axis_i.tlast);

      assign axis_i.tready = (state == EMPTY) | (out_fire & at_last);
      assign axis_o.tvalid = (state == HOLD);
      assign axis_o.tdata  = data_q[phys * 8 * SB +: 8 * SB];
      assign axis_o.tkeep  = keep_q[phys * SB +: SB];
      assign axis_o.tlast  = last_q & at_last & (state == HOLD);

      // State and slice counter registers.
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          state <= EMPTY;
          ctr   <= '0;
        end else begin
          state <= state_nxt;
          ctr   <= ctr_nxt;
        end
      end

      // Next state: step through slices, reload directly on the final slice to avoid a bubble.
      always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        if (state == EMPTY) begin
          if (capture) begin
            state_nxt = HOLD;
            ctr_nxt   = '0;
          end
        end else if (out_fire) begin
          if (at_last) begin
            ctr_nxt   = '0;
            state_nxt = capture ? HOLD : EMPTY;
          end else begin
            ctr_nxt = ctr + 1'b1;
          end
        end
      end

      // Wide word holding register, loaded on every capture.
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          data_q   <= '0;
          keep_q   <= '0;
          last_q   <= 1'b0;
          last_idx <= '0;
        end else if (capture) begin
          data_q   <= axis_i.tdata;
          keep_q   <= axis_i.tkeep;
          last_q   <= axis_i.tlast;
          last_idx <= cap_last_idx;
        end
      end

    end else begin : g_pack
      localparam int RATIO = AXIS_O_BYTES / AXIS_I_BYTES;
      localparam int CW    = $clog2(RATIO);
      localparam int SB    = AXIS_I_BYTES;

      logic [CW-1:0]             ctr, phys;
      logic [8*AXIS_O_BYTES-1:0] acc_data, word_data, out_data;
      logic [AXIS_O_BYTES-1:0]   acc_keep, word_keep, out_keep;
      logic                      out_vld, out_last, in_fire, complete;

      assign axis_i.tready = ~out_vld | axis_o.tready;
      assign in_fire       = axis_i.tvalid & axis_i.tready;
      assign complete      = (ctr == CW'(RATIO - 1)) | axis_i.tlast;
      assign phys          = MSB_FIRST ? (CW'(RATIO - 1) - ctr) : ctr;

      assign axis_o.tvalid = out_vld;
      assign axis_o.tlast  = out_last;
      assign axis_o.tkeep  = out_keep;
      assign axis_o.tdata  = out_data;

      // Accumulator with the current beat merged in, so a completing beat reaches the output in one edge.
      always_comb begin
        word_data = acc_data;
        word_keep = acc_keep;
        word_data[phys * 8 * SB +: 8 * SB] = axis_i.tdata;
        word_keep[phys * SB +: SB]         = axis_i.tkeep;
      end

      // Accumulate narrow beats; hand a finished word to the output register and restart at slice 0.
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          ctr      <= '0;
          acc_data <= '0;
          acc_keep <= '0;
          out_data <= '0;
          out_keep <= '0;
          out_last <= 1'b0;
          out_vld  <= 1'b0;
        end else begin
          if (in_fire) begin
            if (complete) begin
              out_data <= word_data;
              out_keep <= word_keep;
              out_last <= axis_i.tlast;
              acc_data <= '0;
              acc_keep <= '0;
              ctr      <= '0;
            end else begin
              acc_data <= word_data;
              acc_keep <= word_keep;
              ctr      <= ctr + 1'b1;
            end
          end
          if (in_fire & complete) begin
            out_vld <= 1'b1;
          end else if (axis_o.tready) begin
            out_vld <= 1'b0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_axis_width_converter_keep.sv
// Bench for axis_width_converter_keep: 4->1, 1->4, 1->4 MSB-first and 4->2 instances.
// Expected beats come from a byte-stream model; outputs sampled on the falling edge.
// Inputs are driven 1 time unit after the rising edge.
module tb_axis_width_converter_keep;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        irdy;
    int          cyc;
  } beat_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  beat_t q41[$], q14[$], q14m[$], q42[$], exp_q[$];

  axis_width_converter_keep_if #(.BYTES(4)) i41 ();
  axis_width_converter_keep_if #(.BYTES(1)) o41 ();
  axis_width_converter_keep_if #(.BYTES(1)) i14 ();
  axis_width_converter_keep_if #(.BYTES(4)) o14 ();
  axis_width_converter_keep_if #(.BYTES(1)) i14m ();
  axis_width_converter_keep_if #(.BYTES(4)) o14m ();
  axis_width_converter_keep_if #(.BYTES(4)) i42 ();
  axis_width_converter_keep_if #(.BYTES(2)) o42 ();

  axis_width_converter_keep #(.AXIS_I_BYTES(4), .AXIS_O_BYTES(1), .MSB_FIRST(1'b0))
    u41 (.clk(clk), .aresetn(aresetn), .axis_i(i41), .axis_o(o41));
  axis_width_converter_keep #(.AXIS_I_BYTES(1), .AXIS_O_BYTES(4), .MSB_FIRST(1'b0))
    u14 (.clk(clk), .aresetn(aresetn), .axis_i(i14), .axis_o(o14));
  axis_width_converter_keep #(.AXIS_I_BYTES(1), .AXIS_O_BYTES(4), .MSB_FIRST(1'b1))
    u14m (.clk(clk), .aresetn(aresetn), .axis_i(i14m), .axis_o(o14m));
  axis_width_converter_keep #(.AXIS_I_BYTES(4), .AXIS_O_BYTES(2), .MSB_FIRST(1'b0))
    u42 (.clk(clk), .aresetn(aresetn), .axis_i(i42), .axis_o(o42));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l, input logic r);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.irdy = r; b.cyc = cyc;
    return b;
  endfunction

  // Record every output handshake with its cycle and the input ready seen in that cycle.
  always @(negedge clk) begin
    if (o41.tvalid && o41.tready)   q41.push_back(mk(32'(o41.tdata), 4'(o41.tkeep), o41.tlast, i41.tready));
    if (o14.tvalid && o14.tready)   q14.push_back(mk(o14.tdata, o14.tkeep, o14.tlast, i14.tready));
    if (o14m.tvalid && o14m.tready) q14m.push_back(mk(o14m.tdata, o14m.tkeep, o14m.tlast, i14m.tready));
    if (o42.tvalid && o42.tready)   q42.push_back(mk(32'(o42.tdata), 4'(o42.tkeep), o42.tlast, i42.tready));
  end

  // Unpack reference: emit ceil(enabled_bytes / out_bytes) slices; an empty final word gives one empty beat.
  function automatic void unpack_model(input logic [31:0] d, input logic [3:0] k, input logic l, input int ob);
    int nb, ns;
    logic [31:0] m;
    nb = $countones(k);
    ns = (nb + ob - 1) / ob;
    m  = (ob == 1) ? 32'hFF : 32'hFFFF;
    if (ns == 0) begin
      if (l) exp_q.push_back(mk(d & m, 4'h0, 1'b1, 1'b0));
    end else begin
      for (int s = 0; s < ns; s++)
        exp_q.push_back(mk((d >> (8 * ob * s)) & m, 4'((k >> (ob * s)) & ((1 << ob) - 1)),
                           l && (s == ns - 1), 1'b0));
    end
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
    case (sel)
      0: begin i41.tvalid = v; i41.tdata = d; i41.tkeep = k; i41.tlast = l; end
      1: begin i14.tvalid = v; i14.tdata = d[7:0]; i14.tkeep = k[0]; i14.tlast = l; end
      2: begin i14m.tvalid = v; i14m.tdata = d[7:0]; i14m.tkeep = k[0]; i14m.tlast = l; end
      default: begin i42.tvalid = v; i42.tdata = d; i42.tkeep = k; i42.tlast = l; end
    endcase
  endtask

  function automatic logic in_rdy(input int sel);
    case (sel)
      0: return i41.tready;
      1: return i14.tready;
      2: return i14m.tready;
      default: return i42.tready;
    endcase
  endfunction

  // Present one beat until accepted (bounded); returns the acceptance cycle.
  task automatic send(input int sel, input logic [31:0] d, input logic [3:0] k, input logic l,
                      output int acyc, output bit ok);
    bit done;
    done = 1'b0;
    acyc = -1;
    drive(sel, 1'b1, d, k, l);
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_rdy(sel)) begin done = 1'b1; acyc = cyc; end
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, d, k, l);
    ok = done;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    for (int s = 0; s < 4; s++) drive(s, 1'b0, 32'h0, 4'h0, 1'b0);
    o41.tready = 1'b1; o14.tready = 1'b1; o14m.tready = 1'b1; o42.tready = 1'b1;
    #23;
    checks++; if (o41.tvalid !== 1'b0) begin failures++; $display("FAIL reset_o41_tvalid got=%b want=0", o41.tvalid); end
    checks++; if (o41.tlast !== 1'b0) begin failures++; $display("FAIL reset_o41_tlast got=%b want=0", o41.tlast); end
    checks++; if (o41.tkeep !== 1'b0) begin failures++; $display("FAIL reset_o41_tkeep got=%b want=0", o41.tkeep); end
    checks++; if (o41.tdata !== 8'h00) begin failures++; $display("FAIL reset_o41_tdata got=%h want=00", o41.tdata); end
    checks++; if (o14.tvalid !== 1'b0) begin failures++; $display("FAIL reset_o14_tvalid got=%b want=0", o14.tvalid); end
    checks++; if (o14.tlast !== 1'b0) begin failures++; $display("FAIL reset_o14_tlast got=%b want=0", o14.tlast); end
    checks++; if (o14.tkeep !== 4'h0) begin failures++; $display("FAIL reset_o14_tkeep got=%h want=0", o14.tkeep); end
    checks++; if (o14.tdata !== 32'h0) begin failures++; $display("FAIL reset_o14_tdata got=%h want=0", o14.tdata); end
    checks++; if (i41.tready !== 1'b1) begin failures++; $display("FAIL reset_i41_tready got=%b want=1", i41.tready); end
    checks++; if (i14.tready !== 1'b1) begin failures++; $display("FAIL reset_i14_tready got=%b want=1", i14.tready); end
    @(posedge clk); #1;
    aresetn = 1'b1;
    idle(2);
  endtask

  task automatic test_unpack_basic;
    int ac; bit ok;
    q41.delete();
    send(0, 32'hDDCCBBAA, 4'hF, 1'b1, ac, ok);
    idle(6);
    checks++; if (!ok) begin failures++; $display("FAIL unpack_basic_accept timeout"); end
    checks++; if (q41.size() != 4) begin failures++; $display("FAIL unpack_basic_count got=%0d want=4", q41.size()); end
    for (int k = 0; k < q41.size() && k < 4; k++) begin
      logic [31:0] ed;
      ed = (32'hDDCCBBAA >> (8 * k)) & 32'hFF;
      checks++;
      if (q41[k].data !== ed || q41[k].keep !== 4'h1 || q41[k].last !== (k == 3) || q41[k].cyc != ac + 1 + k) begin
        failures++;
        $display("FAIL unpack_basic_beat%0d got d=%h k=%h l=%b cyc=%0d want d=%h k=1 l=%b cyc=%0d",
                 k, q41[k].data, q41[k].keep, q41[k].last, q41[k].cyc, ed, (k == 3), ac + 1 + k);
      end
    end
  endtask

  task automatic test_back_to_back;
    int a0, a1; bit ok0, ok1;
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    q41.delete(); exp_q.delete();
    unpack_model(d0, 4'hF, 1'b0, 1);
    unpack_model(d1, 4'hF, 1'b1, 1);
    send(0, d0, 4'hF, 1'b0, a0, ok0);
    send(0, d1, 4'hF, 1'b1, a1, ok1);
    idle(6);
    checks++; if (!ok0 || !ok1) begin failures++; $display("FAIL b2b_accept timeout ok0=%b ok1=%b", ok0, ok1); end
    checks++; if (q41.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d want=8", q41.size()); end
    for (int k = 0; k < q41.size() && k < 8; k++) begin
      checks++;
      if (q41[k].data !== exp_q[k].data || q41[k].keep !== exp_q[k].keep || q41[k].last !== exp_q[k].last ||
          q41[k].cyc != a0 + 1 + k || q41[k].irdy !== (k == 3 || k == 7)) begin
        failures++;
        $display("FAIL b2b_beat%0d got d=%h l=%b cyc=%0d rdy=%b want d=%h l=%b cyc=%0d rdy=%b",
                 k, q41[k].data, q41[k].last, q41[k].cyc, q41[k].irdy,
                 exp_q[k].data, exp_q[k].last, a0 + 1 + k, (k == 3 || k == 7));
      end
    end
  endtask

  task automatic test_unpack_keep;
    logic [3:0] kt [6];
    logic       lt [6];
    int ac; bit ok;
    kt = '{4'h3, 4'h0, 4'h0, 4'hF, 4'hF, 4'h3};
    lt = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    q42.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d;
      d = $urandom;
      unpack_model(d, kt[i], lt[i], 2);
      send(3, d, kt[i], lt[i], ac, ok);
      checks++; if (!ok) begin failures++; $display("FAIL unpack_keep_accept%0d timeout", i); end
    end
    idle(6);
    checks++; if (q42.size() != exp_q.size()) begin failures++; $display("FAIL unpack_keep_count got=%0d want=%0d", q42.size(), exp_q.size()); end
    for (int k = 0; k < q42.size() && k < exp_q.size(); k++) begin
      checks++;
      if (q42[k].data !== exp_q[k].data || q42[k].keep !== exp_q[k].keep || q42[k].last !== exp_q[k].last) begin
        failures++;
        $display("FAIL unpack_keep_beat%0d got d=%h k=%h l=%b want d=%h k=%h l=%b", k,
                 q42[k].data, q42[k].keep, q42[k].last, exp_q[k].data, exp_q[k].keep, exp_q[k].last);
      end
    end
  endtask

  task automatic test_pack_early_last;
    int a0, a1, a2; bit ok0, ok1, ok2;
    q14.delete();
    send(1, 32'h11, 4'h1, 1'b0, a0, ok0);
    send(1, 32'h22, 4'h1, 1'b0, a1, ok1);
    send(1, 32'h33, 4'h1, 1'b1, a2, ok2);
    idle(4);
    checks++; if (!(ok0 && ok1 && ok2)) begin failures++; $display("FAIL pack_early_accept timeout"); end
    checks++; if (q14.size() != 1) begin failures++; $display("FAIL pack_early_count got=%0d want=1", q14.size()); end
    if (q14.size() > 0) begin
      checks++;
      if (q14[0].data !== 32'h00332211 || q14[0].keep !== 4'b0111 || q14[0].last !== 1'b1 || q14[0].cyc != a2 + 1) begin
        failures++;
        $display("FAIL pack_early_beat got d=%h k=%b l=%b cyc=%0d want d=00332211 k=0111 l=1 cyc=%0d",
                 q14[0].data, q14[0].keep, q14[0].last, q14[0].cyc, a2 + 1);
      end
    end
  endtask

  task automatic test_pack_msb;
    logic [7:0] bt [6];
    logic       lt [6];
    int         acs [6];
    bit         ok, all_ok;
    bt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    lt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    all_ok = 1'b1;
    q14m.delete();
    for (int i = 0; i < 6; i++) begin
      send(2, 32'(bt[i]), 4'h1, lt[i], acs[i], ok);
      all_ok &= ok;
    end
    idle(4);
    checks++; if (!all_ok) begin failures++; $display("FAIL pack_msb_accept timeout"); end
    checks++; if (acs[4] != acs[3] + 1) begin failures++; $display("FAIL pack_msb_next_pkt got=%0d want=%0d", acs[4], acs[3] + 1); end
    checks++; if (q14m.size() != 2) begin failures++; $display("FAIL pack_msb_count got=%0d want=2", q14m.size()); end
    if (q14m.size() > 1) begin
      checks++;
      if (q14m[0].data !== 32'h11223344 || q14m[0].keep !== 4'hF || q14m[0].last !== 1'b1) begin
        failures++;
        $display("FAIL pack_msb_beat0 got d=%h k=%h l=%b want d=11223344 k=f l=1", q14m[0].data, q14m[0].keep, q14m[0].last);
      end
      checks++;
      if (q14m[1].data !== 32'h55660000 || q14m[1].keep !== 4'b1100 || q14m[1].last !== 1'b1) begin
        failures++;
        $display("FAIL pack_msb_beat1 got d=%h k=%b l=%b want d=55660000 k=1100 l=1", q14m[1].data, q14m[1].keep, q14m[1].last);
      end
    end
  endtask

  task automatic test_pack_random;
    bit drv_done;
    q14.delete(); exp_q.delete();
    drv_done = 1'b0;
    fork
      begin
        logic [7:0] pk [16];
        int n, ac; bit ok;
        for (int p = 0; p < 25; p++) begin
          n = $urandom_range(1, 9);
          for (int j = 0; j < n; j++) pk[j] = 8'($urandom);
          for (int base = 0; base < n; base += 4) begin
            logic [31:0] w; logic [3:0] kk;
            w = '0; kk = '0;
            for (int j = 0; j < 4; j++)
              if (base + j < n) begin w |= 32'(pk[base + j]) << (8 * j); kk[j] = 1'b1; end
            exp_q.push_back(mk(w, kk, (base + 4 >= n), 1'b0));
          end
          for (int j = 0; j < n; j++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            send(1, 32'(pk[j]), 4'h1, (j == n - 1), ac, ok);
            checks++; if (!ok) begin failures++; $display("FAIL pack_rand_accept pkt%0d byte%0d timeout", p, j); end
          end
        end
        drv_done = 1'b1;
      end
      begin
        logic hv, hl; logic [31:0] hd; logic [3:0] hk;
        hv = 1'b0; hl = 1'b0; hd = '0; hk = '0;
        for (int t = 0; t < 5000 && !drv_done; t++) begin
          @(posedge clk); #1;
          o14.tready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (hv) begin
            checks++;
            if (o14.tvalid !== 1'b1 || o14.tdata !== hd || o14.tkeep !== hk || o14.tlast !== hl) begin
              failures++;
              $display("FAIL pack_rand_stall got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b",
                       o14.tvalid, o14.tdata, o14.tkeep, o14.tlast, hd, hk, hl);
            end
          end
          hv = o14.tvalid && !o14.tready;
          hd = o14.tdata; hk = o14.tkeep; hl = o14.tlast;
        end
      end
    join
    @(posedge clk); #1;
    o14.tready = 1'b1;
    idle(8);
    checks++; if (q14.size() != exp_q.size()) begin failures++; $display("FAIL pack_rand_count got=%0d want=%0d", q14.size(), exp_q.size()); end
    for (int k = 0; k < q14.size() && k < exp_q.size(); k++) begin
      checks++;
      if (q14[k].data !== exp_q[k].data || q14[k].keep !== exp_q[k].keep || q14[k].last !== exp_q[k].last) begin
        failures++;
        $display("FAIL pack_rand_beat%0d got d=%h k=%h l=%b want d=%h k=%h l=%b", k,
                 q14[k].data, q14[k].keep, q14[k].last, exp_q[k].data, exp_q[k].keep, exp_q[k].last);
      end
    end
  endtask

  task automatic test_reset_mid_packet;
    int ac; bit ok, all_ok;
    all_ok = 1'b1;
    o14.tready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      send(1, 32'($urandom_range(0, 255)), 4'h1, 1'b0, ac, ok);
      all_ok &= ok;
    end
    @(negedge clk);
    checks++; if (o14.tvalid !== 1'b1) begin failures++; $display("FAIL rst_mid_held_valid got=%b want=1", o14.tvalid); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (o14.tvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_async_valid got=%b want=0", o14.tvalid); end
    @(posedge clk); #1;
    aresetn = 1'b1;
    o14.tready = 1'b1;
    send(1, 32'hA1, 4'h1, 1'b0, ac, ok); all_ok &= ok;
    send(1, 32'hA2, 4'h1, 1'b0, ac, ok); all_ok &= ok;
    #3 aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    q14.delete();
    send(1, 32'h55, 4'h1, 1'b0, ac, ok); all_ok &= ok;
    send(1, 32'h66, 4'h1, 1'b1, ac, ok); all_ok &= ok;
    idle(4);
    checks++; if (!all_ok) begin failures++; $display("FAIL rst_mid_accept timeout"); end
    checks++; if (q14.size() != 1) begin failures++; $display("FAIL rst_mid_count got=%0d want=1", q14.size()); end
    if (q14.size() > 0) begin
      checks++;
      if (q14[0].data !== 32'h00006655 || q14[0].keep !== 4'b0011 || q14[0].last !== 1'b1) begin
        failures++;
        $display("FAIL rst_mid_beat got d=%h k=%b l=%b want d=00006655 k=0011 l=1", q14[0].data, q14[0].keep, q14[0].last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unpack_basic();
    test_back_to_back();
    test_unpack_keep();
    test_pack_early_last();
    test_pack_msb();
    test_pack_random();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
